// File: rtl/cpi_serializer.sv
// Cyclic-prefix insertion and serializer: buffers one IFFT symbol, then streams prefix + body.
// Optional sticky misuse flag `err` when CPI_ERR_EN is defined.
module cpi_serializer #(
    parameter int unsigned N      = 64,
    parameter int unsigned CP_LEN = 16,
    parameter int unsigned DW     = 16,
    parameter int unsigned AW     = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_re,
    input  logic [DW-1:0] wr_im,
    input  logic          CPI_start,
    input  logic          CPIdataValid,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          out_cp,
    output logic          out_last,
    output logic          CPI_done,
    output logic          busy
`ifdef CPI_ERR_EN
    ,
    output logic          err
`endif
);

    typedef enum logic [1:0] {StIdle, StPrefix, StBody} state_e;

    state_e          state;
    logic [2*DW-1:0] mem [N];
    logic [AW-1:0]   idx;
    logic [AW-1:0]   cnt;
    logic            fetch_done;
    logic            a_valid;
    logic [AW-1:0]   a_addr;
    logic            a_cp;
    logic            a_last;

    logic start_ok;
    logic out_adv;
    logic a_adv;
    logic issue;
    logic final_xfer;

    assign start_ok   = CPI_start && CPIdataValid;
    assign out_adv    = !out_valid || out_ready;
    assign a_adv      = !a_valid || out_adv;
    assign issue      = (state != StIdle) && !fetch_done;
    assign final_xfer = out_valid && out_ready && out_last;

    // Symbol buffer is deliberately not reset; writes only land while idle.
    always_ff @(posedge clk) begin
        if (wr_en && state == StIdle) begin
            mem[wr_addr] <= {wr_re, wr_im};
        end
    end

    // Two-stage read pipeline: address stage (a_*) feeds the registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_re     <= '0;
            out_im     <= '0;
            out_cp     <= 1'b0;
            out_last   <= 1'b0;
            CPI_done   <= 1'b0;
            idx        <= '0;
            cnt        <= '0;
            fetch_done <= 1'b0;
            a_valid    <= 1'b0;
            a_addr     <= '0;
            a_cp       <= 1'b0;
            a_last     <= 1'b0;
        end else begin
            CPI_done <= 1'b0;

            if (out_adv) begin
                out_valid <= a_valid;
                if (a_valid) begin
                    out_re   <= mem[a_addr][2*DW-1:DW];
                    out_im   <= mem[a_addr][DW-1:0];
                    out_cp   <= a_cp;
                    out_last <= a_last;
                end
            end

            if (a_adv) begin
                a_valid <= issue;
                if (issue) begin
                    a_addr <= idx;
                    a_cp   <= (state == StPrefix);
                    a_last <= (state == StBody) && (idx == AW'(N - 1));
                end
            end

            unique case (state)
                StIdle: begin
                    if (start_ok) begin
                        state      <= StPrefix;
                        busy       <= 1'b1;
                        idx        <= AW'(N - CP_LEN);
                        cnt        <= '0;
                        fetch_done <= 1'b0;
                    end
                end
                StPrefix: begin
                    if (a_adv) begin
                        if (cnt == AW'(CP_LEN - 1)) begin
                            state <= StBody;
                            idx   <= '0;
                            cnt   <= '0;
                        end else begin
                            idx <= idx + AW'(1);
                            cnt <= cnt + AW'(1);
                        end
                    end
                end
                StBody: begin
                    if (a_adv && !fetch_done) begin
                        if (idx == AW'(N - 1)) begin
                            fetch_done <= 1'b1;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                    if (final_xfer) begin
                        state    <= StIdle;
                        busy     <= 1'b0;
                        CPI_done <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef CPI_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (busy && (start_ok || wr_en)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/cpi_serializer.md
# cpi_serializer

Cyclic-prefix insertion and serialization stage at the tail of the baseband modulator, directly downstream of the IFFT and driven by the controller's `CPI_start`/`CPIdataValid` and returning `CPI_done`. It buffers one IFFT symbol of `N` complex samples written by the IFFT stage. On start, it streams `CP_LEN` prefix samples followed by the full symbol, one complex sample per accepted handshake.

## Interface
- `N`, 64: IFFT size in samples; power of two, ≥ 4.
- `CP_LEN`, 16: cyclic-prefix length; 1 ≤ `CP_LEN` ≤ `N`-1.
- `DW`, 16: width of each of I and Q, two's complement.
- `AW`, 6: buffer address width; must equal log2(`N`).

- `clk` input 1: sole clock; all logic updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `wr_en` input 1: write one sample into the symbol buffer.
- `wr_addr` input `AW`: buffer index 0..`N`-1.
- `wr_re`, `wr_im` input `DW`: sample to write.
- `CPI_start` input 1: start request from the controller.
- `CPIdataValid` input 1: qualifies `CPI_start`; a start is accepted only when both are high.
- `out_ready` input 1: downstream accepts the sample.
- `out_valid` output 1: `out_re`/`out_im` hold a valid sample.
- `out_re`, `out_im` output `DW`: serialized sample.
- `out_cp` output 1: current sample belongs to the prefix.
- `out_last` output 1: current sample is the final body sample.
- `CPI_done` output 1: one-cycle completion pulse.
- `busy` output 1: serialization in progress.

## Operation
- Buffer: `N` entries × 2·`DW` bits. Not cleared by reset.
- States: IDLE, PREFIX, BODY.
- IDLE:
  - `wr_en` writes `buffer[wr_addr]`.
  - An accepted start (`CPI_start` && `CPIdataValid`) moves the block to PREFIX, with read index `N`-`CP_LEN`.
- PREFIX: emits buffer indices `N`-`CP_LEN` .. `N`-1 with `out_cp`=1. After the last prefix transfer, the block moves to BODY with index 0.
- BODY: emits indices 0 .. `N`-1 with `out_cp`=0. `out_last`=1 only on index `N`-1. After that transfer, the block pulses `CPI_done` and returns to IDLE.
- A transfer occurs when `out_valid` && `out_ready`. While `out_valid` && !`out_ready`, `out_re`, `out_im`, `out_cp` and `out_last` hold stable. No sample is skipped or duplicated.
- Total per symbol: exactly `N`+`CP_LEN` transfers.
- Ignored while `busy`:
  - `wr_en`; the buffer is unchanged.
  - `CPI_start`.
- Index counters wrap by explicit compare against `N`-1 and `CP_LEN`-1. Unsigned `AW`-bit arithmetic. Sample data passes through unmodified.
- `rst` during PREFIX or BODY aborts the symbol:
  - `out_valid`=0 from the next edge.
  - No `CPI_done` is issued.
  - The block returns to IDLE.

## Timing
- Reset values: `out_valid`=0, `out_re`=0, `out_im`=0, `out_cp`=0, `out_last`=0, `CPI_done`=0, `busy`=0; state IDLE.
- The start is accepted at edge E0.
  - `busy`=1 after E0.
  - `out_valid`=1 after E0+2, presenting index `N`-`CP_LEN` (one registered buffer read).
- With `out_ready` held high, one transfer occurs per cycle. The last sample is presented after E0+1+`N`+`CP_LEN`.
- On the edge following the final transfer:
  - `CPI_done`=1 for exactly one cycle.
  - `busy`=0.
  - `out_valid`=0, unless a new sample pipeline has started.
- A start is accepted in the same cycle `CPI_done` is high, which allows back-to-back symbols.
- A write in IDLE is visible to a start accepted on the following edge.
- A write in the same cycle as an accepted start takes effect.

## Configuration
- `CPI_ERR_EN` defined:
  - Adds output `err` (1 bit, reset 0, sticky until `rst`).
  - `err` is set by `CPI_start`&&`CPIdataValid` while `busy`.
  - `err` is set by `wr_en` while `busy`.
- `CPI_ERR_EN` undefined: no `err` port. Both events are silently ignored; behaviour is otherwise identical.

## Test plan
- Basic stream: `N`=64, `CP_LEN`=16, buffer `re`=addr, `im`=-addr, `out_ready`=1, start at E0.
  - Expect 80 transfers: `re`=48..63 with `out_cp`=1, then 0..63 with `out_cp`=0.
  - `out_last` on `re`=63 of the body only; `CPI_done` a single pulse at E0+82.
- Backpressure: same data, `out_ready` toggling 1,0,1,0… → identical 80-sample sequence, outputs stable while stalled, `CPI_done` after the 80th transfer.
- Start while busy: a second start at sample 10 → stream unaffected, single `CPI_done`; with `CPI_ERR_EN`, `err`=1.
- Write while busy: `wr_en` to addr 0 with `re`=0x7FFF during PREFIX → body index 0 still outputs `re`=0; `err`=1 if enabled.
- Reset mid-symbol: `rst` at body sample 30 → `out_valid`=0 next cycle, no `CPI_done`, `busy`=0. A fresh start then yields the full 80-sample sequence (buffer retained).
- Back-to-back: second start during the `CPI_done` cycle → the second symbol's first sample appears two edges later, no gap in `busy` beyond one cycle.
